// File: rtl/breakout_block_column.sv
// breakout_block_column: one column of ROWS breakout blocks.
// Draws the present blocks, evaluates a ball/block collision once per frame,
// removes (or weakens) the hit block, pulses bounce directions to the ball
// logic and keeps a saturating column score.
// Optional feature macro: MULTI_HIT_EN (2-bit block strength, reload 3).
//
// Handshake note: there is no valid/ready flow control here. frame_tick is a
// fire-and-forget strobe that is only accepted in IDLE (latched) or COOL
// (counted); hit_valid is a one-cycle strobe coincident with move_* and the
// ball logic must take it in that cycle, since nothing back-pressures it.
//
// dbg_state encoding: 0 = IDLE, 1 = EVAL, 2 = HIT, 3 = COOL.
module breakout_block_column #(
  parameter int ROWS        = 8,
  parameter int X_L         = 122,
  parameter int X_R         = 227,
  parameter int Y0          = 4,
  parameter int ROW_H       = 16,
  parameter int PITCH       = 23,
  parameter int EDGE        = 3,
  parameter int EXT         = 7,
  parameter int SCORE_MULT  = 1,
  parameter int CNT_W       = 6,
  parameter int COOL_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             frame_tick,
  input  logic [10:0]      pix_x,
  input  logic [10:0]      pix_y,
  input  logic [10:0]      ball_x_l,
  input  logic [10:0]      ball_x_r,
  input  logic [10:0]      ball_y_t,
  input  logic [10:0]      ball_y_b,
  output logic             col_on,
  output logic             move_u,
  output logic             move_d,
  output logic             move_l,
  output logic             move_r,
  output logic             hit_valid,
  output logic [3:0]       hit_row,
  output logic [CNT_W-1:0] col_count,
  output logic             col_empty,
  output logic [1:0]       dbg_state
);

`ifdef MULTI_HIT_EN
  localparam int SW = 2;
`else
  localparam int SW = 1;
`endif
  localparam logic [SW-1:0] RELOAD = '1;
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);
  localparam logic [SUM_W-1:0] MULT = SUM_W'(SCORE_MULT);
  localparam logic [7:0] COOL_INIT = 8'(COOL_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_HIT  = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SW-1:0] strength [ROWS];
  logic [ROWS-1:0] present;
  logic [10:0] lat_xl, lat_xr, lat_yt, lat_yb;
  logic [7:0] cool;
  logic [3:0] hit_faces;  // {u, d, l, r} of the winning row

  int xl_i, xr_i, yt_i, yb_i, px_i, py_i;
  logic [ROWS-1:0] f_u, f_d, f_l, f_r, on_row;
  logic found;
  logic [3:0] win_row;
  logic [3:0] win_faces;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count_next;

  assign xl_i = int'(lat_xl);
  assign xr_i = int'(lat_xr);
  assign yt_i = int'(lat_yt);
  assign yb_i = int'(lat_yb);
  assign px_i = int'(pix_x);
  assign py_i = int'(pix_y);

  // Per-row face detection on the latched ball box and per-row drawing.
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    localparam int T = Y0 + g * PITCH;
    localparam int B = T + ROW_H - 1;
    logic x_win, y_ovl;
    assign present[g] = |strength[g];
    assign x_win  = (xl_i >= X_L - EXT) && (xr_i <= X_R + EXT);
    assign y_ovl  = (yb_i >= T) && (yt_i <= B);
    assign f_d[g] = present[g] && (yt_i >= T) && (yt_i <= B) && (yt_i >= B - EDGE) && x_win;
    assign f_u[g] = present[g] && (yb_i <= B) && (yb_i >= T) && (yb_i <= T + EDGE) && x_win;
    assign f_l[g] = present[g] && (xr_i >= X_L) && (xr_i <= X_L + EDGE) && y_ovl;
    assign f_r[g] = present[g] && (xl_i >= X_R - EDGE) && (xl_i <= X_R) && y_ovl;
    assign on_row[g] = present[g] && (px_i >= X_L) && (px_i <= X_R) &&
                       (py_i >= T) && (py_i <= B);
  end

  assign col_on    = |on_row;
  assign col_empty = ~|present;

  // Priority encoder: scanning downward leaves the lowest hit row as winner.
  always_comb begin
    found     = 1'b0;
    win_row   = '0;
    win_faces = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (f_u[r] || f_d[r] || f_l[r] || f_r[r]) begin
        found     = 1'b1;
        win_row   = 4'(r);
        win_faces = {f_u[r], f_d[r], f_l[r], f_r[r]};
      end
    end
  end

  // Saturating score increment, computed with headroom so overflow clamps.
  always_comb begin
    sum        = {4'b0, col_count} + MULT;
    count_next = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  // State register; clear wins over every other event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state <= S_IDLE;
    else if (clear) state <= S_IDLE;
    else            state <= state_next;
  end

  // Next-state logic; ticks in EVAL and HIT are ignored.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (frame_tick) state_next = S_EVAL;
      S_EVAL: state_next = found ? S_HIT : S_IDLE;
      S_HIT:  state_next = (COOL_FRAMES == 0) ? S_IDLE : S_COOL;
      S_COOL: if (frame_tick && cool <= 8'd1) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: bounce pulses live only in HIT.
  always_comb begin
    hit_valid = (state == S_HIT);
    move_u    = hit_valid && hit_faces[3];
    move_d    = hit_valid && hit_faces[2];
    move_l    = hit_valid && hit_faces[1];
    move_r    = hit_valid && hit_faces[0];
    dbg_state = state;
  end

  // Datapath: coordinate latch, hit capture, block removal, score, cooldown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) strength[r] <= RELOAD;
      lat_xl    <= '0;
      lat_xr    <= '0;
      lat_yt    <= '0;
      lat_yb    <= '0;
      cool      <= '0;
      hit_row   <= '0;
      hit_faces <= '0;
      col_count <= '0;
    end else if (clear) begin
      for (int r = 0; r < ROWS; r++) strength[r] <= RELOAD;
      cool      <= '0;
      hit_row   <= '0;
      hit_faces <= '0;
      col_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (frame_tick) begin
            lat_xl <= ball_x_l;
            lat_xr <= ball_x_r;
            lat_yt <= ball_y_t;
            lat_yb <= ball_y_b;
          end
        end
        S_EVAL: begin
          if (found) begin
            hit_row   <= win_row;
            hit_faces <= win_faces;
          end
        end
        S_HIT: begin
          // Only the winning block loses strength; it scores when it dies.
          for (int r = 0; r < ROWS; r++) begin
            if (hit_row == 4'(r) && strength[r] != '0) begin
              strength[r] <= strength[r] - SW'(1);
              if (strength[r] == SW'(1)) col_count <= count_next;
            end
          end
          cool <= COOL_INIT;
        end
        S_COOL: begin
          if (frame_tick && cool != '0) cool <= cool - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_breakout_block_column.sv
// Bench for breakout_block_column: directed scenarios followed by random ball
// positions, each event compared against a frame-level behavioural model.
module tb_breakout_block_column;

  localparam int ROWS        = 8;
  localparam int X_L         = 122;
  localparam int X_R         = 227;
  localparam int Y0          = 4;
  localparam int ROW_H       = 16;
  localparam int PITCH       = 23;
  localparam int EDGE        = 3;
  localparam int EXT         = 7;
  localparam int SCORE_MULT  = 10;
  localparam int CNT_W       = 6;
  localparam int COOL_FRAMES = 2;
  localparam int CNT_MAX     = 63;
`ifdef MULTI_HIT_EN
  localparam int RELOAD = 3;
`else
  localparam int RELOAD = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic clear = 1'b0, frame_tick = 1'b0;
  logic [10:0] pix_x = '0, pix_y = '0;
  logic [10:0] ball_x_l = '0, ball_x_r = '0, ball_y_t = '0, ball_y_b = '0;
  logic col_on, move_u, move_d, move_l, move_r, hit_valid, col_empty;
  logic [3:0] hit_row;
  logic [CNT_W-1:0] col_count;
  logic [1:0] dbg_state;

  breakout_block_column #(
    .ROWS(ROWS), .X_L(X_L), .X_R(X_R), .Y0(Y0), .ROW_H(ROW_H), .PITCH(PITCH),
    .EDGE(EDGE), .EXT(EXT), .SCORE_MULT(SCORE_MULT), .CNT_W(CNT_W),
    .COOL_FRAMES(COOL_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .frame_tick(frame_tick),
    .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
    .col_on(col_on), .move_u(move_u), .move_d(move_d), .move_l(move_l), .move_r(move_r),
    .hit_valid(hit_valid), .hit_row(hit_row), .col_count(col_count),
    .col_empty(col_empty), .dbg_state(dbg_state)
  );

  // ---------------- behavioural model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int str [ROWS];   // remaining hits per block
  int m_count;      // expected score
  int m_cool;       // frame ticks still to be swallowed
  int m_row;        // expected held hit_row

  function automatic int row_t(input int r);
    return Y0 + r * PITCH;
  endfunction

  // Face flags {u, d, l, r} of block r for a ball box, straight from the face rules.
  function automatic logic [3:0] faces(input int r, input int xl, input int xr,
                                       input int yt, input int yb);
    int t, b;
    bit xw, u, d, l, rr;
    t  = row_t(r);
    b  = t + ROW_H - 1;
    xw = (xl >= X_L - EXT) && (xr <= X_R + EXT);
    d  = (yt >= t) && (yt <= b) && (yt >= b - EDGE) && xw;
    u  = (yb <= b) && (yb >= t) && (yb <= t + EDGE) && xw;
    l  = (xr >= X_L) && (xr <= X_L + EDGE) && (yb >= t) && (yt <= b);
    rr = (xl >= X_R - EDGE) && (xl <= X_R) && (yb >= t) && (yt <= b);
    return {u, d, l, rr};
  endfunction

  function automatic bit m_empty();
    for (int r = 0; r < ROWS; r++) if (str[r] > 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_on(input int px, input int py);
    for (int r = 0; r < ROWS; r++)
      if (str[r] > 0 && px >= X_L && px <= X_R && py >= row_t(r) && py <= row_t(r) + ROW_H - 1)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reload();
    for (int r = 0; r < ROWS; r++) str[r] = RELOAD;
    m_count = 0;
    m_cool  = 0;
    m_row   = 0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_pix(input int px, input int py);
    pix_x = 11'(px);
    pix_y = 11'(py);
    #1;
    check("col_on", {31'b0, col_on}, {31'b0, m_on(px, py)});
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reload();
  endtask

  // One frame: present the ball box, pulse frame_tick, check the three cycles after.
  task automatic run_event(input int xl, input int xr, input int yt, input int yb);
    logic [3:0] ef;
    int w;
    ef = '0;
    w  = -1;
    if (m_cool > 0) m_cool--;
    else begin
      for (int r = 0; r < ROWS; r++)
        if (w < 0 && str[r] > 0 && faces(r, xl, xr, yt, yb) != 4'b0) begin
          w  = r;
          ef = faces(r, xl, xr, yt, yb);
        end
    end
    @(negedge clk);
    ball_x_l = 11'(xl);
    ball_x_r = 11'(xr);
    ball_y_t = 11'(yt);
    ball_y_b = 11'(yb);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("quiet_tick1", {27'b0, hit_valid, move_u, move_d, move_l, move_r}, 32'd0);
    @(negedge clk);
    if (w >= 0) m_row = w;
    check("pulse", {27'b0, hit_valid, move_u, move_d, move_l, move_r}, {27'b0, (w >= 0), ef});
    check("hit_row", {28'b0, hit_row}, 32'(m_row));
    if (w >= 0) begin
      str[w]--;
      if (str[w] == 0) m_count = (m_count + SCORE_MULT > CNT_MAX) ? CNT_MAX : m_count + SCORE_MULT;
      m_cool = COOL_FRAMES;
    end
    @(negedge clk);
    check("quiet_tick3", {27'b0, hit_valid, move_u, move_d, move_l, move_r}, 32'd0);
    check("col_count", {26'b0, col_count}, 32'(m_count));
    check("col_empty", {31'b0, col_empty}, {31'b0, m_empty()});
  endtask

  task automatic drain_cool();
    for (int i = 0; i < 8 && m_cool > 0; i++) run_event(0, 7, 300, 307);
  endtask

  task automatic hit_right(input int r);
    drain_cool();
    run_event(225, 232, row_t(r) + 3, row_t(r) + 10);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t, xl, yt, sel, r;
    model_reload();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pulse", {27'b0, hit_valid, move_u, move_d, move_l, move_r}, 32'd0);
    check("rst_count", {26'b0, col_count}, 32'd0);
    check("rst_empty", {31'b0, col_empty}, 32'd0);
    check("rst_row", {28'b0, hit_row}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    reset = 1'b1;

    // Drawing edges
    check_pix(X_L, Y0);
    check_pix(X_L - 1, Y0);
    check_pix(X_R, Y0 + ROW_H - 1);
    check_pix(X_R + 1, Y0 + ROW_H - 1);
    check_pix(150, Y0 + ROW_H);
    check_pix(150, Y0 - 1);

    // Right-face hit on row 1
    run_event(225, 232, 30, 37);
    check("t1_row", {28'b0, hit_row}, 32'd1);
    check_pix(150, 30);
    // Cooldown: two swallowed ticks, third evaluated on row 2
    run_event(225, 232, 53, 60);
    run_event(225, 232, 53, 60);
    run_event(225, 232, 53, 60);
    check("t2_row", {28'b0, hit_row}, 32'd2);

    // Bottom hit on row 0, then overlap of rows 0 and 1 after a reload
    drain_cool();
    run_event(150, 157, 18, 25);
    do_clear();
    run_event(150, 157, 18, 28);
    check_pix(150, 10);
    check_pix(150, 30);

    // Left-face and corner hits
    do_clear();
    run_event(116, 123, row_t(4) + 2, row_t(4) + 9);
    drain_cool();
    run_event(117, 124, row_t(5) - 4, row_t(5) + 3);

    // Saturation and empty column, then reload
    do_clear();
    for (int row = 0; row < ROWS; row++)
      for (int k = 0; k < 4 && str[row] > 0; k++) hit_right(row);
    check("sat_count", {26'b0, col_count}, 32'd63);
    check("sat_empty", {31'b0, col_empty}, 32'd1);
    check_pix(150, 10);
    do_clear();
    @(negedge clk);
    check("clr_count", {26'b0, col_count}, 32'd0);
    check("clr_empty", {31'b0, col_empty}, 32'd0);
    check_pix(150, 10);

    // Reset asserted while in HIT: nothing removed, outputs drop at once
    @(negedge clk);
    ball_x_l = 11'd225; ball_x_r = 11'd232; ball_y_t = 11'd30; ball_y_b = 11'd37;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check("mid_pulse", {31'b0, move_r}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_pulse", {27'b0, hit_valid, move_u, move_d, move_l, move_r}, 32'd0);
    check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reload();
    @(negedge clk);
    check("mid_rst_count", {26'b0, col_count}, 32'd0);
    check_pix(150, 30);
    run_event(225, 232, 30, 37);

    // Repeated hits on row 3 (strength behaviour)
    do_clear();
    for (int k = 0; k < 3; k++) hit_right(3);

    // Random ball positions around the column
    do_clear();
    for (int i = 0; i < 80; i++) begin
      if (i % 30 == 29) do_clear();
      r   = $urandom_range(0, ROWS - 1);
      t   = row_t(r);
      sel = $urandom_range(0, 4);
      case (sel)
        0: begin xl = $urandom_range(221, 230); yt = t - 7 + $urandom_range(0, ROW_H + 6); end
        1: begin xl = $urandom_range(112, 120); yt = t - 7 + $urandom_range(0, ROW_H + 6); end
        2: begin xl = $urandom_range(110, 232); yt = t + ROW_H - 1 - $urandom_range(0, 5); end
        3: begin xl = $urandom_range(110, 232); yt = t - 7 + $urandom_range(0, 5); end
        default: begin xl = $urandom_range(90, 250); yt = $urandom_range(0, 200); end
      endcase
      if (yt < 0) yt = 0;
      run_event(xl, xl + 7, yt, yt + 7);
      check_pix($urandom_range(110, 240), $urandom_range(0, 190));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
